// File: rtl/plic_claim_pkg.sv
// Shared types and constants for the PLIC claim/complete AXI master.
package plic_claim_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AR      = 3'd1,
        S_R       = 3'd2,
        S_DELIVER = 3'd3,
        S_WR      = 3'd4,
        S_B       = 3'd5
    } state_e;

    localparam logic [31:0] CLAIM_OFFSET   = 32'h0020_0004;
    localparam logic [31:0] CTX_STRIDE     = 32'h0000_1000;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;

    function automatic logic [31:0] claim_addr(
        input logic [31:0] base,
        input int unsigned tgt
    );
        return base + CLAIM_OFFSET + CTX_STRIDE * 32'(tgt);
    endfunction

endpackage

// File: rtl/plic_claim_master_if.sv
// Single-beat AXI4 master bundle used by the PLIC claim master.
interface plic_claim_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/plic_claim_wr_tracker.sv
// Tracks the independent AW and W handshakes of one write.
module plic_claim_wr_tracker (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_done
);

    logic r_aw_pend;
    logic r_w_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else if (i_start) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
        end else begin
            if (r_aw_pend && i_awready) r_aw_pend <= 1'b0;
            if (r_w_pend && i_wready)   r_w_pend  <= 1'b0;
        end
    end

    assign o_awvalid = r_aw_pend;
    assign o_wvalid  = r_w_pend;

    // Done covers both channels finishing in the same cycle.
    assign o_done = (r_aw_pend | r_w_pend)
                  & (~r_aw_pend | i_awready)
                  & (~r_w_pend | i_wready);

endmodule

// File: rtl/plic_claim_master.sv
// Claims a PLIC source ID over AXI, hands it to the core, and writes it back
// on completion.
module plic_claim_master
    import plic_claim_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH  = 32,
    parameter int          AXI_ADDR_WIDTH  = 32,
    parameter int          AXI_ID_WIDTH    = 4,
    parameter int          AXI_ID          = 0,
    parameter logic [31:0] PLIC_BASE       = 32'h0400_0000,
    parameter int          TARGET_ID       = 0,
    parameter int          SRCW            = 5,
    parameter int          MAX_OUTSTANDING = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            irq_i,
    output logic            claim_valid_o,
    input  logic            claim_ready_i,
    output logic [SRCW-1:0] claim_id_o,
    input  logic            complete_valid_i,
    output logic            complete_ready_o,
    input  logic [SRCW-1:0] complete_id_i,
    output logic            err_o,
    plic_claim_master_if.master m_axi
);

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_AR      = S_AR;
    localparam logic [2:0] ST_R       = S_R;
    localparam logic [2:0] ST_DELIVER = S_DELIVER;
    localparam logic [2:0] ST_WR      = S_WR;
    localparam logic [2:0] ST_B       = S_B;

    localparam logic [AXI_ADDR_WIDTH-1:0] CLAIM_ADDR =
        AXI_ADDR_WIDTH'(claim_addr(PLIC_BASE, TARGET_ID));
    localparam logic [AXI_ID_WIDTH-1:0] ID_C = AXI_ID_WIDTH'(AXI_ID);
    localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);

    logic [2:0]      r_state;
    logic [2:0]      r_count;
    logic [SRCW-1:0] r_claim_id;
    logic [SRCW-1:0] r_cpl_id;
    logic            r_err;

    logic            w_cpl_go;
    logic            w_wr_done;
    logic            w_rd_ok;
    logic            w_b_ok;
    logic [SRCW-1:0] w_rd_id;
    logic            w_unused;

    assign w_cpl_go = (r_state == ST_IDLE) & complete_valid_i;
    assign w_rd_id  = m_axi.rdata[SRCW-1:0];
    assign w_rd_ok  = (m_axi.rresp == AXI_RESP_OKAY);
    assign w_b_ok   = (m_axi.bresp == AXI_RESP_OKAY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_claim_id <= '0;
            r_cpl_id   <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Completion wins so freed slots are returned first.
                    if (complete_valid_i) begin
                        r_cpl_id <= complete_id_i;
                        r_state  <= ST_WR;
                    end else if (irq_i && (r_count < MAX_C)) begin
                        r_state <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axi.arready) r_state <= ST_R;
                end
                ST_R: begin
                    if (m_axi.rvalid) begin
                        if (!w_rd_ok) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_rd_id == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_claim_id <= w_rd_id;
                            r_count    <= r_count + 3'd1;
                            r_state    <= ST_DELIVER;
                        end
                    end
                end
                ST_DELIVER: begin
                    if (claim_ready_i) r_state <= ST_IDLE;
                end
                ST_WR: begin
                    if (w_wr_done) r_state <= ST_B;
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        if (r_count != '0) r_count <= r_count - 3'd1;
                        if (!w_b_ok) r_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    plic_claim_wr_tracker u_wr_tracker (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_start   (w_cpl_go),
        .i_awready (m_axi.awready),
        .i_wready  (m_axi.wready),
        .o_awvalid (m_axi.awvalid),
        .o_wvalid  (m_axi.wvalid),
        .o_done    (w_wr_done)
    );

    assign claim_valid_o    = (r_state == ST_DELIVER);
    assign claim_id_o       = r_claim_id;
    assign complete_ready_o = (r_state == ST_IDLE);
    assign err_o            = r_err;

    assign m_axi.arid    = ID_C;
    assign m_axi.araddr  = CLAIM_ADDR;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = AXI_SIZE_4B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arvalid = (r_state == ST_AR);
    assign m_axi.rready  = (r_state == ST_R);

    assign m_axi.awid    = ID_C;
    assign m_axi.awaddr  = CLAIM_ADDR;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = AXI_SIZE_4B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wdata   = AXI_DATA_WIDTH'(r_cpl_id);
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = (r_state == ST_B);

    // Single outstanding transaction: IDs and rlast carry no information.
    assign w_unused = ^{m_axi.rid, m_axi.rlast, m_axi.bid,
                        m_axi.rdata[AXI_DATA_WIDTH-1:SRCW]};

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed plus randomized bench for plic_claim_master with an AXI slave
// driven inline and a transaction-level claim/complete model.
module tb_plic_claim_master;

    localparam logic [31:0] EXP_ADDR = 32'h0420_0004;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       irq_i;
    logic       claim_valid_o;
    logic       claim_ready_i;
    logic [4:0] claim_id_o;
    logic       complete_valid_i;
    logic       complete_ready_o;
    logic [4:0] complete_id_i;
    logic       err_o;

    plic_claim_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) ax ();

    plic_claim_master dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .irq_i            (irq_i),
        .claim_valid_o    (claim_valid_o),
        .claim_ready_i    (claim_ready_i),
        .claim_id_o       (claim_id_o),
        .complete_valid_i (complete_valid_i),
        .complete_ready_o (complete_ready_o),
        .complete_id_i    (complete_id_i),
        .err_o            (err_o),
        .m_axi            (ax)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_count = 0;
    bit         m_err = 1'b0;
    logic [4:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic claim_txn(input logic [31:0] data, input logic [1:0] resp,
                             input int ar_dly, input int r_dly,
                             output bit delivered);
        int n;
        n = 0;
        while (ax.arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ar_valid", 32'(ax.arvalid), 32'd1);
        chk("ar_addr", ax.araddr, EXP_ADDR);
        chk("ar_attr", 32'({ax.arid, ax.arlen, ax.arsize, ax.arburst}),
            32'({4'd0, 8'd0, 3'b010, 2'b01}));
        for (int i = 0; i < ar_dly; i++) begin
            tick();
            chk("ar_hold", 32'(ax.arvalid), 32'd1);
            chk("ar_hold_addr", ax.araddr, EXP_ADDR);
        end
        ax.arready = 1'b1;
        tick();
        ax.arready = 1'b0;
        chk("ar_drop", 32'(ax.arvalid), 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            chk("r_ready_wait", 32'(ax.rready), 32'd1);
            tick();
        end
        chk("r_ready", 32'(ax.rready), 32'd1);
        ax.rvalid = 1'b1;
        ax.rdata  = data;
        ax.rresp  = resp;
        ax.rlast  = 1'b1;
        ax.rid    = 4'd0;
        tick();
        ax.rvalid = 1'b0;
        ax.rdata  = $urandom;
        ax.rresp  = 2'($urandom);
        if (resp != 2'b00) m_err = 1'b1;
        delivered = (resp == 2'b00) && (data[4:0] != 5'd0);
        if (delivered) begin
            m_count++;
            m_q.push_back(data[4:0]);
        end
        chk("claim_valid", 32'(claim_valid_o), 32'(delivered));
        if (delivered) chk("claim_id", 32'(claim_id_o), 32'(data[4:0]));
        chk("err_after_r", 32'(err_o), 32'(m_err));
        chk("count_after_r", 32'(dut.r_count), 32'(m_count));
    endtask

    task automatic accept_claim(input int dly);
        logic [4:0] id;
        id = m_q[$];
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("claim_hold", 32'(claim_valid_o), 32'd1);
            chk("claim_id_hold", 32'(claim_id_o), 32'(id));
        end
        claim_ready_i = 1'b1;
        tick();
        claim_ready_i = 1'b0;
        chk("claim_drop", 32'(claim_valid_o), 32'd0);
    endtask

    task automatic complete_txn(input logic [4:0] id, input int aw_dly,
                                input int w_dly, input int b_dly,
                                input logic [1:0] bresp);
        bit aw_done;
        bit w_done;
        int c;
        chk("cpl_ready", 32'(complete_ready_o), 32'd1);
        complete_valid_i = 1'b1;
        complete_id_i    = id;
        tick();
        complete_valid_i = 1'b0;
        complete_id_i    = 5'($urandom);
        chk("cpl_ready_busy", 32'(complete_ready_o), 32'd0);
        chk("no_ar_in_wr", 32'(ax.arvalid), 32'd0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        c = 0;
        while (!(aw_done && w_done) && c < 16) begin
            chk("aw_valid", 32'(ax.awvalid), 32'(!aw_done));
            chk("w_valid", 32'(ax.wvalid), 32'(!w_done));
            if (!aw_done) begin
                chk("aw_addr", ax.awaddr, EXP_ADDR);
                chk("aw_attr", 32'({ax.awid, ax.awlen, ax.awsize, ax.awburst}),
                    32'({4'd0, 8'd0, 3'b010, 2'b01}));
            end
            if (!w_done) begin
                chk("w_data", ax.wdata, {27'd0, id});
                chk("w_strb_last", 32'({ax.wstrb, ax.wlast}), 32'h1F);
            end
            ax.awready = !aw_done && (c >= aw_dly);
            ax.wready  = !w_done && (c >= w_dly);
            tick();
            if (ax.awready) aw_done = 1'b1;
            if (ax.wready)  w_done  = 1'b1;
            ax.awready = 1'b0;
            ax.wready  = 1'b0;
            c++;
        end
        chk("wr_bound", 32'(aw_done && w_done), 32'd1);
        chk("aw_idle_in_b", 32'(ax.awvalid), 32'd0);
        chk("w_idle_in_b", 32'(ax.wvalid), 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            chk("b_ready_wait", 32'(ax.bready), 32'd1);
            tick();
        end
        chk("b_ready", 32'(ax.bready), 32'd1);
        ax.bvalid = 1'b1;
        ax.bresp  = bresp;
        ax.bid    = 4'd0;
        tick();
        ax.bvalid = 1'b0;
        if (m_count > 0) m_count--;
        if (bresp != 2'b00) m_err = 1'b1;
        chk("b_drop", 32'(ax.bready), 32'd0);
        chk("idle_after_b", 32'(complete_ready_o), 32'd1);
        chk("count_after_b", 32'(dut.r_count), 32'(m_count));
        chk("err_after_b", 32'(err_o), 32'(m_err));
    endtask

    initial begin
        bit         d;
        int         n;
        int         r;
        logic [31:0] data;
        logic [1:0]  resp;

        rst_i = 1'b1;
        irq_i = 1'b0;
        claim_ready_i = 1'b0;
        complete_valid_i = 1'b0;
        complete_id_i = 5'd0;
        ax.arready = 1'b0;
        ax.rid = 4'd0;
        ax.rdata = 32'd0;
        ax.rresp = 2'd0;
        ax.rlast = 1'b0;
        ax.rvalid = 1'b0;
        ax.awready = 1'b0;
        ax.wready = 1'b0;
        ax.bid = 4'd0;
        ax.bresp = 2'd0;
        ax.bvalid = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_arvalid", 32'(ax.arvalid), 32'd0);
        chk("rst_awvalid", 32'(ax.awvalid), 32'd0);
        chk("rst_wvalid", 32'(ax.wvalid), 32'd0);
        chk("rst_rready", 32'(ax.rready), 32'd0);
        chk("rst_bready", 32'(ax.bready), 32'd0);
        chk("rst_claim_valid", 32'(claim_valid_o), 32'd0);
        chk("rst_claim_id", 32'(claim_id_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_count", 32'(dut.r_count), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("idle_ready", 32'(complete_ready_o), 32'd1);

        // 1: claim of 7, AR one cycle after irq sampled
        irq_i = 1'b1;
        chk("ar_before_edge", 32'(ax.arvalid), 32'd0);
        tick();
        chk("ar_rise", 32'(ax.arvalid), 32'd1);
        claim_txn(32'd7, 2'b00, 0, 0, d);
        accept_claim(1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_second_ar", 32'(ax.arvalid), 32'd0);
        end

        // 2: complete 7 with late awready, immediate wready
        complete_txn(m_q.pop_front(), 2, 0, 0, 2'b00);

        // 3: spurious claim, new AR on the next IDLE cycle
        claim_txn(32'd0, 2'b00, 1, 1, d);
        chk("spurious_idle_ar", 32'(ax.arvalid), 32'd0);
        tick();
        chk("spurious_re_ar", 32'(ax.arvalid), 32'd1);

        // 4: SLVERR then a clean claim of 3
        claim_txn(32'd3, 2'b10, 0, 2, d);
        claim_txn(32'd3, 2'b00, 0, 0, d);
        accept_claim(0);
        complete_txn(m_q.pop_front(), 0, 1, 1, 2'b00);

        // 5: completion and irq together; write goes first
        irq_i = 1'b0;
        n = 0;
        while (ax.arvalid === 1'b1 || complete_ready_o !== 1'b1) begin
            if (ax.arvalid === 1'b1) begin
                ax.arready = 1'b1;
                tick();
                ax.arready = 1'b0;
                ax.rvalid = 1'b1;
                ax.rdata = 32'd0;
                ax.rresp = 2'b00;
                tick();
                ax.rvalid = 1'b0;
            end else begin
                tick();
            end
            n++;
            if (n > 8) break;
        end
        chk("t5_idle", 32'(complete_ready_o), 32'd1);
        irq_i = 1'b1;
        complete_txn(5'd9, 1, 1, 0, 2'b00);
        claim_txn(32'd12, 2'b00, 0, 0, d);
        accept_claim(0);

        // 6: reset while AR pending
        complete_txn(m_q.pop_front(), 0, 0, 0, 2'b00);
        n = 0;
        while (ax.arvalid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("t6_ar_pending", 32'(ax.arvalid), 32'd1);
        rst_i = 1'b1;
        tick();
        m_count = 0;
        m_err = 1'b0;
        m_q.delete();
        chk("t6_arvalid", 32'(ax.arvalid), 32'd0);
        chk("t6_awvalid", 32'(ax.awvalid), 32'd0);
        chk("t6_wvalid", 32'(ax.wvalid), 32'd0);
        chk("t6_claim_valid", 32'(claim_valid_o), 32'd0);
        chk("t6_idle", 32'(complete_ready_o), 32'd1);
        chk("t6_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("t6_reissue", 32'(ax.arvalid), 32'd1);
        claim_txn(32'd21, 2'b00, 1, 0, d);
        accept_claim(2);
        complete_txn(m_q.pop_front(), 1, 2, 1, 2'b00);

        // randomized claim/complete traffic
        for (int it = 0; it < 40; it++) begin
            data = $urandom;
            if ($urandom_range(0, 5) == 0) data[4:0] = 5'd0;
            r = $urandom_range(0, 15);
            resp = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'b00;
            claim_txn(data, resp, $urandom_range(0, 3),
                      $urandom_range(0, 3), d);
            if (d) begin
                accept_claim($urandom_range(0, 2));
                complete_txn(m_q.pop_front(), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 2),
                             ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00);
            end else if ($urandom_range(0, 2) == 0) begin
                complete_txn(5'($urandom), $urandom_range(0, 2),
                             $urandom_range(0, 2), $urandom_range(0, 2),
                             2'b00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
